rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Shares one N:1 data multiplexer between N requesters using round-robin arbitration.
- The winning request is captured into a single registered output stage with a valid/ready handshake.
- Sits in front of a shared downstream consumer. Gives fair, starvation-free access at one transfer per cycle.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, data width of each requester and of the output.
- IDW, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N  bit i = requester i presents data.
- req_data  input  N*W  requester i data in bits [i*W +: W].
- req_ready  output  N  bit i = requester i's data is taken this cycle (combinational).
- out_valid  output  1  output register holds a valid item.
- out_data  output  W  registered data of the selected requester.
- out_id  output  IDW  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0, round-robin pointer ptr=0.
- Drain condition: drain = out_valid & out_ready.
- Load condition: load = |req_valid & (~out_valid | out_ready).
  - An item may load in the same cycle the previous one drains, giving full throughput of 1 item/cycle.
- Grant g: the first i with req_valid[i]=1, searching from index ptr upward and wrapping modulo N. The search is purely combinational.
- req_ready[g] = load; every other req_ready bit = 0. At most one bit is ever high. req_ready = 0 whenever load = 0.
- On load:
  - out_valid <= 1, out_data <= req_data[g], out_id <= g.
  - ptr <= (g+1) mod N. Wrap from N-1 goes to 0; N not a power of 2 must wrap correctly.
- On drain without load: out_valid <= 0; out_data and out_id hold their last values.
- When neither load nor drain: all state holds.
  - A stalled output (out_valid=1, out_ready=0) keeps out_data and out_id stable.
  - A stalled output leaves ptr unchanged and blocks all req_ready.
- ptr changes only on load. Idle cycles never advance it.
- Latency: a request granted at edge k appears on out_valid/out_data after edge k; that is 1 cycle.
- Requesters follow valid/ready rules: a requester keeps req_valid and req_data stable until its req_ready is seen high. The arbiter does not depend on this for correctness; it samples req_data only at load.
- Simultaneous events:
  - Drain plus new request in the same cycle: load wins, out_valid stays 1 with new data.
  - All N requesting: grants rotate ptr, ptr+1, … in strict order.
  - A single requester repeatedly requesting gets every cycle.
- Reset mid-transfer: the output item is discarded (out_valid=0 immediately, asynchronously) and ptr returns to 0. No req_ready pulses while rst=1.
- Datapath select is a binary-index mux over req_data; out_data is never a combination of several requesters.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, release, req_valid=0 for 5 cycles.
  - Required: out_valid=0, out_data=0, out_id=0, req_ready=0 throughout.
- Full contention:
  - Stimulus: N=4, W=8; req_valid=4'b1111 constant; req_data = {8'h44,8'h33,8'h22,8'h11} (i=3..0); out_ready=1.
  - Required: out_id sequence 0,1,2,3,0,1; out_data sequence 11,22,33,44,11; out_valid=1 every cycle after the first.
- Pointer skip and wrap:
  - Stimulus: after requester 2 is granted (ptr=3), req_valid=4'b0101.
  - Required: next grant is 0 (wraps past empty 3), then 2, then 0.
- Backpressure:
  - Stimulus: out_valid=1 with out_id=1, out_data=22; out_ready=0 for 3 cycles while req_valid=4'b1111.
  - Required: out_data=22 and out_id=1 hold; req_ready=0; ptr unchanged. With out_ready=1 in the next cycle: req_ready=4'b0100, and 33 loads the following cycle.
- Drain without refill:
  - Stimulus: out_valid=1, out_ready=1, req_valid=0.
  - Required: out_valid=0 next cycle; out_data keeps its last value.
- Async reset mid-stream:
  - Stimulus: assert rst between edges during the full-contention run.
  - Required: out_valid drops to 0 before the next edge. After release, the first grant is requester 0.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 data mux, feeding a single registered
// valid/ready output stage. One transfer per cycle at full throughput.
module rr_mux_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_id,
  input  logic             out_ready
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant;
  logic           found;
  logic           load;
  logic [W-1:0]   sel_data;

  // Grant search: first requester at or above ptr, else first from index 0 (wrap).
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= ptr_q)) begin
        grant = IDW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_valid[i]) begin
        grant = IDW'(i);
        found = 1'b1;
      end
    end
  end

  // Load whenever someone requests and the output slot is empty or draining.
  // Gated by rst so no handshake completes while reset is held.
  assign load = (|req_valid) & (~out_valid | out_ready) & ~rst;

  // Next pointer is one past the grant, wrapping explicitly for non-power-of-2 N.
  assign ptr_d = (grant == IDW'(N - 1)) ? '0 : grant + IDW'(1);

  // Binary-index data mux and one-hot ready for the granted requester.
  always_comb begin
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == IDW'(i)) begin
        sel_data     = req_data[i*W +: W];
        req_ready[i] = load;
      end
    end
  end

  // Output register and round-robin pointer; ptr moves only on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr_q     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_id    <= grant;
      ptr_q     <= ptr_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Reference model state
  bit       m_valid = 1'b0;
  int       m_data  = 0;
  int       m_id    = 0;
  int       m_ptr   = 0;

  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin search: first requesting index from ptr upward, modulo N.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Model advance on each clock edge / async reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 0;
      m_id    = 0;
      m_ptr   = 0;
    end else begin
      int g;
      g = model_grant();
      if (g >= 0 && (!m_valid || out_ready)) begin
        m_valid = 1'b1;
        m_data  = int'(req_data[g*W +: W]);
        m_id    = g;
        m_ptr   = (g + 1) % N;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare DUT against model mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      int g;
      logic [N-1:0] exp_rr;
      g = model_grant();
      exp_rr = '0;
      if (!rst && g >= 0 && (!m_valid || out_ready)) exp_rr[g] = 1'b1;
      check("model out_valid", 32'(out_valid), 32'(m_valid));
      check("model out_data", 32'(out_data), m_data);
      check("model out_id", 32'(out_id), m_id);
      check("model req_ready", 32'(req_ready), 32'(exp_rr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_ids [6] = '{0, 1, 2, 3, 0, 1};
  int exp_dat [6] = '{'h11, 'h22, 'h33, 'h44, 'h11, 'h22};

  initial begin
    // Reset then idle
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle out_valid", 32'(out_valid), 0);
      check("idle out_data", 32'(out_data), 0);
      check("idle out_id", 32'(out_id), 0);
      check("idle req_ready", 32'(req_ready), 0);
    end

    // Full contention
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    out_ready = 1'b1;
    #1 check("contention first ready", 32'(req_ready), 32'b0001);
    for (int j = 0; j < 6; j++) begin
      tick();
      check("contention out_valid", 32'(out_valid), 1);
      check("contention out_id", 32'(out_id), exp_ids[j]);
      check("contention out_data", 32'(out_data), exp_dat[j]);
    end

    // Backpressure: holding id 1 / data 22, ptr = 2
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1 check("stall req_ready", 32'(req_ready), 0);
      tick();
      check("stall out_data", 32'(out_data), 'h22);
      check("stall out_id", 32'(out_id), 1);
    end
    out_ready = 1'b1;
    #1 check("release req_ready", 32'(req_ready), 32'b0100);
    tick();
    check("release out_data", 32'(out_data), 'h33);
    check("release out_id", 32'(out_id), 2);

    // Pointer skip and wrap (ptr = 3)
    req_valid = 4'b0101;
    #1 check("skip req_ready", 32'(req_ready), 32'b0001);
    tick();
    check("skip id a", 32'(out_id), 0);
    tick();
    check("skip id b", 32'(out_id), 2);
    tick();
    check("skip id c", 32'(out_id), 0);
    check("skip data c", 32'(out_data), 'h11);

    // Drain without refill
    req_valid = '0;
    tick();
    check("drain out_valid", 32'(out_valid), 0);
    check("drain out_data", 32'(out_data), 'h11);
    check("drain out_id", 32'(out_id), 0);

    // Async reset mid-stream (ptr = 1)
    req_valid = 4'b1111;
    tick();
    check("prereset id", 32'(out_id), 1);
    tick();
    check("prereset out_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset out_valid", 32'(out_valid), 0);
    check("async reset req_ready", 32'(req_ready), 0);
    tick();
    rst = 1'b0;
    #1 check("post reset req_ready", 32'(req_ready), 32'b0001);
    tick();
    check("post reset out_id", 32'(out_id), 0);
    check("post reset out_data", 32'(out_data), 'h11);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) req_valid = req_valid & N'($urandom_range(0, (1 << N) - 1));
      req_data  = {$urandom};
      out_ready = ($urandom_range(0, 3) != 0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
